// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a width x height sprite from a sprite-sheet RAM into
// the 240x160 framebuffer. It processes one pixel per clock, skips pixels that
// match the transparency key, and clips pixels that land off screen.
module sprite_blitter #(
    parameter int          FB_W = 240,
    parameter int          FB_H = 160,
    parameter logic [23:0] KEY  = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [18:0] src_base,
    input  logic [9:0]  src_stride,
    input  logic [7:0]  width,
    input  logic [7:0]  height,
    input  logic [8:0]  dst_x,
    input  logic [7:0]  dst_y,
    input  logic        use_key,
    output logic [18:0] src_addr,
    input  logic [23:0] src_data,
    output logic [18:0] fb_addr,
    output logic [23:0] fb_data,
    output logic        fb_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t      state, next_state;

    // Copy of the command, captured when the blit is accepted.
    logic [9:0]  stride_q;
    logic [7:0]  width_q;
    logic [7:0]  height_q;
    logic [8:0]  dst_x_q;
    logic [7:0]  dst_y_q;
    logic        use_key_q;

    // Raster walk over the sprite.
    logic [18:0] row_base;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        last_col;
    logic        last_pix;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;

    // Coordinates of the pixel whose sheet data arrives this cycle.
    logic        p1_valid;
    logic [9:0]  p1_x;
    logic [8:0]  p1_y;
    logic        in_bounds;
    logic        transparent;
    logic [18:0] wr_addr;
    logic        done_q;

    assign last_col    = (col == width_q - 8'd1);
    assign last_pix    = last_col && (row == height_q - 8'd1);
    assign src_addr    = row_base + {11'd0, col};
    assign pix_x       = {1'b0, dst_x_q} + {2'b0, col};
    assign pix_y       = {1'b0, dst_y_q} + {1'b0, row};
    assign in_bounds   = (p1_x < 10'(FB_W)) && (p1_y < 9'(FB_H));
    assign transparent = use_key_q && (src_data == KEY);
    assign wr_addr     = ({10'd0, p1_y} * 19'(FB_W)) + {9'd0, p1_x};
    assign busy        = (state != IDLE);
    assign done        = done_q;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an empty sprite skips the pixel walk entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((width == 8'd0) || (height == 8'd0)) begin
                        next_state = DONE;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (last_pix) begin
                    next_state = FLUSH;
                end
            end
            FLUSH:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command capture and raster counters; row_base advances by one sheet row per sprite row.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            stride_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
            dst_x_q   <= '0;
            dst_y_q   <= '0;
            use_key_q <= 1'b0;
            row_base  <= '0;
            col       <= '0;
            row       <= '0;
        end else if ((state == IDLE) && start) begin
            stride_q  <= src_stride;
            width_q   <= width;
            height_q  <= height;
            dst_x_q   <= dst_x;
            dst_y_q   <= dst_y;
            use_key_q <= use_key;
            row_base  <= src_base;
            col       <= '0;
            row       <= '0;
        end else if (state == RUN) begin
            if (last_col) begin
                col      <= '0;
                row      <= row + 8'd1;
                row_base <= row_base + {9'd0, stride_q};
            end else begin
                col      <= col + 8'd1;
            end
        end
    end

    // Delay the destination coordinates to line up with the sheet RAM's registered read.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            p1_valid <= 1'b0;
            p1_x     <= '0;
            p1_y     <= '0;
        end else begin
            p1_valid <= (state == RUN);
            p1_x     <= pix_x;
            p1_y     <= pix_y;
        end
    end

    // Framebuffer write stage; clipped or keyed pixels still pass through but do not write.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= p1_valid && in_bounds && !transparent;
            if (p1_valid) begin
                fb_addr <= wr_addr;
                fb_data <= src_data;
            end
        end
    end

    // Completion pulse, issued as the FSM leaves DONE so it coincides with busy falling.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed and random blits compared cycle by cycle against
// a per-pixel model of the blit, plus literal expectations for the classic cases.
module tb_sprite_blitter;

    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [18:0] src_base;
    logic [9:0]  src_stride;
    logic [7:0]  width;
    logic [7:0]  height;
    logic [8:0]  dst_x;
    logic [7:0]  dst_y;
    logic        use_key;
    logic [18:0] src_addr;
    logic [23:0] src_data;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic        done;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int idle_from = 0;
    int horizon   = 0;
    bit checking  = 1'b0;

    // Expected values keyed by edge number (value seen after that edge).
    logic [23:0] sheet_ovr [int];
    bit          exp_we    [int];
    logic [18:0] exp_addr  [int];
    logic [23:0] exp_data  [int];
    bit          exp_busy  [int];
    bit          exp_done  [int];
    logic [18:0] exp_src   [int];
    bit          exp_rst   [int];

    sprite_blitter dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .src_base   (src_base),
        .src_stride (src_stride),
        .width      (width),
        .height     (height),
        .dst_x      (dst_x),
        .dst_y      (dst_y),
        .use_key    (use_key),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .busy       (busy),
        .done       (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sheet contents: explicit overrides, otherwise a hash with occasional key pixels.
    function automatic logic [23:0] sheet_rd(input logic [18:0] a);
        logic [31:0] h;
        if (sheet_ovr.exists(int'(a))) return sheet_ovr[int'(a)];
        h = {13'd0, a} * 32'h2545F491 + 32'h01234567;
        h = h ^ (h >> 15);
        if (h[3:0] == 4'd0) return KEY;
        return h[31:8];
    endfunction

    // Sprite-sheet RAM with one-cycle registered read.
    always @(posedge Clk) src_data <= sheet_rd(src_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Fills the expectation tables for a blit accepted at edge e.
    task automatic schedule(input int e, input int base, input int stride, input int w,
                            input int h, input int dx, input int dy, input bit key);
        int n;
        n = w * h;
        if (n == 0) begin
            exp_busy[e]     = 1'b1;
            exp_done[e + 1] = 1'b1;
            idle_from       = e + 2;
        end else begin
            for (int t = e; t <= e + n + 1; t++) exp_busy[t] = 1'b1;
            exp_done[e + n + 2] = 1'b1;
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    int k, ai, x, y;
                    logic [23:0] d;
                    k  = r * w + c;
                    ai = (base + r * stride + c) % 524288;
                    exp_src[e + k] = ai[18:0];
                    d  = sheet_rd(ai[18:0]);
                    x  = dx + c;
                    y  = dy + r;
                    if (x < 240 && y < 160 && !(key && d == KEY)) begin
                        exp_we[e + k + 2]   = 1'b1;
                        exp_addr[e + k + 2] = 19'(y * 240 + x);
                        exp_data[e + k + 2] = d;
                    end
                end
            end
            idle_from = e + n + 3;
        end
        if (horizon < idle_from) horizon = idle_from;
    endtask

    // Model: counts edges, watches reset and accepted commands.
    initial forever begin
        @(posedge Clk);
        cyc = cyc + 1;
        if (!Reset_n) begin
            for (int t = cyc; t <= horizon; t++) begin
                exp_we.delete(t);
                exp_addr.delete(t);
                exp_data.delete(t);
                exp_busy.delete(t);
                exp_done.delete(t);
                exp_src.delete(t);
            end
            exp_rst[cyc] = 1'b1;
            idle_from    = cyc + 1;
            if (horizon < cyc) horizon = cyc;
            checking = 1'b1;
        end else if (start && cyc >= idle_from) begin
            schedule(cyc, int'(src_base), int'(src_stride), int'(width), int'(height),
                     int'(dst_x), int'(dst_y), use_key);
        end
    end

    // Compare process: DUT against model every cycle, sampled on the falling edge.
    initial forever begin
        @(negedge Clk);
        if (checking) begin
            bit ew;
            ew = exp_we.exists(cyc);
            checkOutput("busy", 32'(busy), 32'(exp_busy.exists(cyc)));
            checkOutput("done", 32'(done), 32'(exp_done.exists(cyc)));
            checkOutput("fb_we", 32'(fb_we), 32'(ew));
            if (ew) begin
                checkOutput("fb_addr", 32'(fb_addr), 32'(exp_addr[cyc]));
                checkOutput("fb_data", 32'(fb_data), 32'(exp_data[cyc]));
            end
            if (exp_src.exists(cyc)) checkOutput("src_addr", 32'(src_addr), 32'(exp_src[cyc]));
            if (exp_rst.exists(cyc)) begin
                checkOutput("rst_fb_addr", 32'(fb_addr), 32'd0);
                checkOutput("rst_fb_data", 32'(fb_data), 32'd0);
                checkOutput("rst_src_addr", 32'(src_addr), 32'd0);
            end
        end
    end

    task automatic waitCycle(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    task automatic waitDone(input int limit, input string name);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge Clk);
            n++;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    // Issues one command as soon as the blitter is free; e is the edge that samples start.
    task automatic applyStimulus(input int base, input int stride, input int w, input int h,
                                 input int dx, input int dy, input bit key, input bit hold,
                                 output int e);
        while (cyc + 1 < idle_from) @(negedge Clk);
        src_base   = 19'(base);
        src_stride = 10'(stride);
        width      = 8'(w);
        height     = 8'(h);
        dst_x      = 9'(dx);
        dst_y      = 8'(dy);
        use_key    = key;
        start      = 1'b1;
        e          = cyc + 1;
        @(negedge Clk);
        if (!hold) start = 1'b0;
        src_base   = 19'($urandom);
        src_stride = 10'($urandom);
        width      = 8'($urandom);
        height     = 8'($urandom);
        dst_x      = 9'($urandom);
        dst_y      = 8'($urandom);
        use_key    = 1'($urandom);
    endtask

    initial begin
        int e;
        Reset_n    = 1'b0;
        start      = 1'b0;
        src_base   = '0;
        src_stride = '0;
        width      = '0;
        height     = '0;
        dst_x      = '0;
        dst_y      = '0;
        use_key    = 1'b0;
        repeat (2) @(negedge Clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_fb_we", 32'(fb_we), 32'd0);
        Reset_n = 1'b1;

        // 2x2 copy to the top-left corner.
        sheet_ovr[0] = 24'h111111;
        sheet_ovr[1] = 24'h222222;
        sheet_ovr[2] = 24'h333333;
        sheet_ovr[3] = 24'h444444;
        applyStimulus(0, 2, 2, 2, 0, 0, 1'b0, 1'b0, e);
        waitCycle(e + 2);
        checkOutput("b2x2_we0", 32'(fb_we), 32'd1);
        checkOutput("b2x2_addr0", 32'(fb_addr), 32'd0);
        checkOutput("b2x2_data0", 32'(fb_data), 32'h111111);
        waitCycle(e + 4);
        checkOutput("b2x2_addr2", 32'(fb_addr), 32'd240);
        checkOutput("b2x2_data2", 32'(fb_data), 32'h333333);
        waitCycle(e + 5);
        checkOutput("b2x2_addr3", 32'(fb_addr), 32'd241);
        checkOutput("b2x2_data3", 32'(fb_data), 32'h444444);
        waitCycle(e + 6);
        checkOutput("b2x2_done", 32'(done), 32'd1);

        // Transparency with and without the key enabled.
        sheet_ovr[100] = 24'hAAAAAA;
        sheet_ovr[101] = KEY;
        sheet_ovr[102] = 24'hBBBBBB;
        applyStimulus(100, 3, 3, 1, 10, 5, 1'b1, 1'b0, e);
        waitCycle(e + 2);
        checkOutput("key_addr0", 32'(fb_addr), 32'd1210);
        waitCycle(e + 3);
        checkOutput("key_skip", 32'(fb_we), 32'd0);
        waitCycle(e + 4);
        checkOutput("key_addr2", 32'(fb_addr), 32'd1212);
        applyStimulus(100, 3, 3, 1, 10, 5, 1'b0, 1'b0, e);
        waitCycle(e + 3);
        checkOutput("nokey_we1", 32'(fb_we), 32'd1);
        checkOutput("nokey_addr1", 32'(fb_addr), 32'd1211);
        checkOutput("nokey_data1", 32'(fb_data), 32'(KEY));

        // Clipping at the bottom-right corner.
        applyStimulus(200, 3, 3, 2, 239, 159, 1'b0, 1'b0, e);
        waitCycle(e + 2);
        checkOutput("clip_we", 32'(fb_we), 32'd1);
        checkOutput("clip_addr", 32'(fb_addr), 32'd38399);
        waitCycle(e + 3);
        checkOutput("clip_off", 32'(fb_we), 32'd0);
        waitCycle(e + 8);
        checkOutput("clip_done", 32'(done), 32'd1);

        // Zero-sized sprite.
        applyStimulus(0, 0, 0, 5, 0, 0, 1'b0, 1'b0, e);
        checkOutput("zero_busy", 32'(busy), 32'd1);
        waitCycle(e + 1);
        checkOutput("zero_done", 32'(done), 32'd1);
        waitCycle(e + 2);
        checkOutput("zero_idle", 32'(busy), 32'd0);

        // Reset in the middle of a 16x16 blit, then a fresh blit.
        applyStimulus(1000, 16, 16, 16, 20, 20, 1'b1, 1'b0, e);
        waitCycle(e + 20);
        Reset_n = 1'b0;
        @(negedge Clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_we", 32'(fb_we), 32'd0);
        Reset_n = 1'b1;
        applyStimulus(0, 2, 2, 2, 30, 30, 1'b0, 1'b0, e);
        waitDone(20, "post_reset_done");

        // Start held high through a 4x4 blit with a different command behind it.
        applyStimulus(300, 4, 4, 4, 50, 60, 1'b0, 1'b1, e);
        src_base   = 19'd400;
        src_stride = 10'd7;
        width      = 8'd2;
        height     = 8'd2;
        dst_x      = 9'd100;
        dst_y      = 8'd70;
        use_key    = 1'b0;
        waitCycle(e + 18);
        checkOutput("held_done", 32'(done), 32'd1);
        checkOutput("held_busy_low", 32'(busy), 32'd0);
        waitCycle(e + 19);
        checkOutput("held_second_busy", 32'(busy), 32'd1);
        checkOutput("held_second_src", 32'(src_addr), 32'd400);
        start = 1'b0;
        waitDone(20, "held_second_done");

        // Random blits, including wrapped source addresses and partial clipping.
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 1) repeat ($urandom_range(0, 3)) @(negedge Clk);
            applyStimulus(int'($urandom_range(0, 524287)), int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 12)), int'($urandom_range(0, 10)),
                          int'($urandom_range(0, 300)), int'($urandom_range(0, 200)),
                          1'($urandom), 1'b0, e);
        end
        waitCycle(idle_from + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
